// File: rtl/full_adder.sv
// Registered one-bit full adder with optional bit-serial carry chaining.
// When SERIAL_EN=1 the carry-out of each accepted bit is stored and becomes
// the carry-in of the next accepted bit, unless start marks a new operand.
// When SERIAL_EN=0 the external c_in is always the carry-in.
//
// Handshake: in_valid qualifies a_in/b_in/c_in/start for one cycle. There is
// no ready; every valid input is accepted. out_valid is high for exactly
// the one cycle after an accepted input, and sum/carry hold their values
// while no input is accepted.
module full_adder #(
    parameter bit SERIAL_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic start,
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    output logic sum,
    output logic carry,
    output logic out_valid
);

    // Carry chained between serial bits; survives idle gaps.
    logic       carry_state;
    logic       cin_eff;
    logic [1:0] total;

    // Select carry-in and form the two-bit sum of the three input bits.
    always_comb begin
        cin_eff = c_in;
        if (SERIAL_EN && !start) begin
            cin_eff = carry_state;
        end
        total = {1'b0, a_in} + {1'b0, b_in} + {1'b0, cin_eff};
    end

    // Register outputs and carry state; reset wins over a valid input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum         <= 1'b0;
            carry       <= 1'b0;
            out_valid   <= 1'b0;
            carry_state <= 1'b0;
        end else if (in_valid) begin
            sum         <= total[0];
            carry       <= total[1];
            out_valid   <= 1'b1;
            carry_state <= total[1];
        end else begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: one serial instance and one
// non-serial instance share the same stimulus and are compared every
// cycle against an arithmetic model, plus literal expectations.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic start;
    logic a_in;
    logic b_in;
    logic c_in;
    logic sum1, carry1, vld1;
    logic sum0, carry0, vld0;

    int errors = 0;
    int checks = 0;

    // Model state
    bit   model_ok = 1'b0;
    int   m1_carry_state = 0;
    int   m0_carry_state = 0;
    logic e1_sum = 0, e1_carry = 0, e1_vld = 0;
    logic e0_sum = 0, e0_carry = 0, e0_vld = 0;

    full_adder #(.SERIAL_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .start(start),
        .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .sum(sum1), .carry(carry1), .out_valid(vld1)
    );

    full_adder #(.SERIAL_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .start(start),
        .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .sum(sum0), .carry(carry0), .out_valid(vld0)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] got, input logic [1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b want=%b at %0t", name, got, want, $time);
        end
    endtask

    // Behavioural model: plain integer addition of the three bits.
    always @(posedge clk) begin
        int cin, total;
        if (rst) begin
            model_ok = 1'b1;
            m1_carry_state = 0; m0_carry_state = 0;
            e1_sum = 0; e1_carry = 0; e1_vld = 0;
            e0_sum = 0; e0_carry = 0; e0_vld = 0;
        end else if (in_valid) begin
            cin = start ? int'(c_in) : m1_carry_state;
            total = int'(a_in) + int'(b_in) + cin;
            e1_sum = logic'(total % 2); e1_carry = logic'(total / 2); e1_vld = 1;
            m1_carry_state = total / 2;
            total = int'(a_in) + int'(b_in) + int'(c_in);
            e0_sum = logic'(total % 2); e0_carry = logic'(total / 2); e0_vld = 1;
            m0_carry_state = total / 2;
        end else begin
            e1_vld = 0;
            e0_vld = 0;
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            check("ser_sum",   {1'b0, sum1},   {1'b0, e1_sum});
            check("ser_carry", {1'b0, carry1}, {1'b0, e1_carry});
            check("ser_valid", {1'b0, vld1},   {1'b0, e1_vld});
            check("par_sum",   {1'b0, sum0},   {1'b0, e0_sum});
            check("par_carry", {1'b0, carry0}, {1'b0, e0_carry});
            check("par_valid", {1'b0, vld0},   {1'b0, e0_vld});
        end
    end

    // Apply one cycle of inputs, return after the following negedge.
    task automatic step(input logic r, input logic v, input logic s,
                        input logic a, input logic b, input logic c);
        rst = r; in_valid = v; start = s; a_in = a; b_in = b; c_in = c;
        @(negedge clk);
    endtask

    logic [1:0] tbl [8];
    logic [3:0] op_a, op_b, sums;

    initial begin
        tbl = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
        op_a = 4'b1011;
        op_b = 4'b0110;
        rst = 1; in_valid = 0; start = 0; a_in = 0; b_in = 0; c_in = 0;
        @(negedge clk);
        step(1, 0, 0, 0, 0, 0);
        check("reset_state", {sum1, carry1}, 2'b00);
        check("reset_valid", {1'b0, vld1}, 2'b00);

        // Exhaustive truth table with start=1.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] abc;
            abc = 3'(i);
            step(0, 1, 1, abc[2], abc[1], abc[0]);
            check($sformatf("truth_%0d", i), {sum1, carry1}, tbl[i]);
            check($sformatf("truth_vld_%0d", i), {1'b0, vld1}, 2'b01);
        end

        // Serial add 1011 + 0110, LSB first.
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, (i == 0), op_a[i], op_b[i], 1'b0);
            sums[i] = sum1;
        end
        check("serial_sum", sums[1:0], 2'b01);
        check("serial_sum_hi", sums[3:2], 2'b00);
        check("serial_carry", {1'b0, carry1}, 2'b01);

        // Same add with a two-cycle idle gap between bit1 and bit2.
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                for (int g = 0; g < 2; g++) begin
                    step(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    check("gap_valid", {1'b0, vld1}, 2'b00);
                    check("gap_hold", {sum1, carry1}, 2'b01);
                end
            end
            step(0, 1, (i == 0), op_a[i], op_b[i], 1'b0);
            sums[i] = sum1;
        end
        check("gap_sum", {sums, 2'b00} >> 2 == 4'b0001 ? 2'b01 : 2'b00, 2'b01);
        check("gap_carry", {1'b0, carry1}, 2'b01);

        // Reset after bit1 aborts the operation.
        step(0, 1, 1, op_a[0], op_b[0], 1'b0);
        step(0, 1, 0, op_a[1], op_b[1], 1'b0);
        step(1, 0, 0, 0, 0, 0);
        check("midrst_out", {sum1, carry1}, 2'b00);
        check("midrst_vld", {1'b0, vld1}, 2'b00);
        step(0, 1, 0, 1, 1, 0);
        check("midrst_next", {sum1, carry1}, 2'b01);

        // Non-serial instance uses c_in regardless of start.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 1);
        check("par_cin", {sum0, carry0}, 2'b01);
        check("ser_nocin", {sum1, carry1}, 2'b10);

        // Reset priority over a valid input.
        step(0, 1, 1, 1, 1, 1);
        step(1, 1, 1, 1, 1, 1);
        check("rst_prio", {sum1, carry1}, 2'b00);
        check("rst_prio_vld", {1'b0, vld1}, 2'b00);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
